// File: rtl/snn_axi_pkg.sv
// snn_axi_pkg: shared sizing constants and FSM state encodings for the SNN AXI input path
package snn_axi_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int NIB_WIDTH  = 4;
  localparam int INPUT_SIZE = 784;
  localparam int TSTEP_NUM  = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_PRES  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/spike_word_unpacker.sv
// spike_word_unpacker: pops FIFO words and offers them nibble by nibble, one frame per timestep
module spike_word_unpacker #(
  parameter int WORD_WIDTH = snn_axi_pkg::WORD_WIDTH,
  parameter int NIB_WIDTH  = snn_axi_pkg::NIB_WIDTH,
  parameter int FRAME_BITS = snn_axi_pkg::INPUT_SIZE,
  parameter int TSTEP_NUM  = snn_axi_pkg::TSTEP_NUM
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [NIB_WIDTH-1:0]  din_parallel,
  output logic                  din_valid,
  input  logic                  pts_ready,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            frame_cnt
);
  import snn_axi_pkg::*;
  localparam int NPW = WORD_WIDTH / NIB_WIDTH;
  localparam int NPF = FRAME_BITS / NIB_WIDTH;
  localparam int NIW = $clog2(NPW);
  localparam int FNW = $clog2(NPF);
  localparam logic [NIW-1:0] NIB_LAST   = NIW'(NPW - 1);
  localparam logic [FNW-1:0] FNIB_LAST  = FNW'(NPF - 1);
  localparam logic [3:0]     FRAME_LAST = 4'(TSTEP_NUM - 1);
  if (NIB_WIDTH != 4) begin : g_bad_nib
    $error("NIB_WIDTH must be 4");
  end
  if (WORD_WIDTH % NIB_WIDTH != 0 || FRAME_BITS % NIB_WIDTH != 0) begin : g_bad_div
    $error("WORD_WIDTH and FRAME_BITS must be multiples of NIB_WIDTH");
  end
  if (TSTEP_NUM < 1 || TSTEP_NUM > 16) begin : g_bad_tstep
    $error("TSTEP_NUM must be 1..16");
  end
  logic [2:0]            state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [NIW-1:0]        nib_q, nib_d;
  logic [FNW-1:0]        fnib_q, fnib_d;
  logic [3:0]            fcnt_q, fcnt_d;
  logic                  xfer;
  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_DONE;
  assign din_valid    = state_q == S_PRES;
  assign fifo_rd_en   = state_q == S_FETCH && !fifo_empty;
  assign din_parallel = din_valid ? word_q[nib_q*NIB_WIDTH +: NIB_WIDTH] : '0;
  assign frame_cnt    = fcnt_q;
  assign xfer         = din_valid && pts_ready;
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    nib_d   = nib_q;
    fnib_d  = fnib_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        nib_d   = '0;
        fnib_d  = '0;
        fcnt_d  = '0;
      end
      S_FETCH: state_d = fifo_empty ? S_FETCH : S_CAPT;
      S_CAPT: begin
        word_d  = fifo_dout;
        nib_d   = '0;
        state_d = S_PRES;
      end
      S_PRES: if (xfer) begin
        fnib_d = fnib_q + 1'b1;
        // a frame end drops whatever is left of the current word
        if (fnib_q == FNIB_LAST) begin
          fnib_d  = '0;
          state_d = fcnt_q == FRAME_LAST ? S_DONE : S_FETCH;
          fcnt_d  = fcnt_q == FRAME_LAST ? fcnt_q : fcnt_q + 1'b1;
        end else if (nib_q == NIB_LAST) begin
          state_d = S_FETCH;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      nib_q   <= '0;
      fnib_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      nib_q   <= nib_d;
      fnib_q  <= fnib_d;
      fcnt_q  <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_spike_word_unpacker.sv
// tb_spike_word_unpacker: random-stimulus bench checking nibble order, frames and handshakes against a word-list model
module tb_spike_word_unpacker;
  localparam int NPF = 196;
  localparam int WPF = 25;
  localparam int RUN_XFERS = 16 * NPF;
  logic        CLK = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [3:0]  din_parallel;
  logic        din_valid;
  logic        pts_ready = 0;
  logic        busy;
  logic        done;
  logic [3:0]  frame_cnt;
  logic [31:0] mem [0:1023];
  int rd_ptr = 0, wr_ptr = 0, run_base = 0, n = 0, done_cnt = 0;
  int n_checks = 0, n_fail = 0;
  logic stall = 0, hold_low = 0, full_ready = 1, mon_en = 0;
  logic hold_v = 0, prev_done = 0;
  logic [3:0] hold_d = '0;
  spike_word_unpacker dut (
    .CLK(CLK), .rst(rst), .start(start), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .din_parallel(din_parallel), .din_valid(din_valid),
    .pts_ready(pts_ready), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );
  always #5 CLK = ~CLK;
  assign fifo_empty = stall || (rd_ptr == wr_ptr);
  always @(posedge CLK) if (fifo_rd_en) begin
    fifo_dout <= mem[rd_ptr];
    rd_ptr <= rd_ptr + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] ref_nib(input int idx);
    int f, k;
    logic [31:0] w;
    f = idx / NPF;
    k = idx % NPF;
    w = mem[run_base + f * WPF + k / 8];
    return 4'((w >> (4 * (k % 8))) & 32'hF);
  endfunction
  initial forever begin
    @(posedge CLK);
    #1;
    pts_ready = hold_low ? 1'b0 : (full_ready ? 1'b1 : ($urandom_range(0, 3) != 0));
  end
  always @(negedge CLK) begin
    if (mon_en) begin
      if (fifo_empty) check("no_pop_when_empty", fifo_rd_en, 0);
      if (!din_valid) check("nibble_zero_idle", din_parallel, 0);
      if (hold_v) begin
        check("hold_valid", din_valid, 1);
        check("hold_data", din_parallel, hold_d);
      end
      if (din_valid && pts_ready) begin
        check("nibble", din_parallel, ref_nib(n));
        check("frame_cnt", frame_cnt, n / NPF);
        n++;
      end
      if (prev_done) begin
        check("done_width", done, 0);
        check("busy_fall", busy, 0);
      end
      if (done) begin
        check("done_after_all", n, RUN_XFERS);
        check("busy_in_done", busy, 1);
        done_cnt++;
      end
      hold_v = din_valid && !pts_ready;
      hold_d = din_parallel;
      prev_done = done;
    end else begin
      hold_v = 0;
      prev_done = 0;
    end
  end
  task automatic load(input int cnt, input bit special);
    for (int i = 0; i < cnt; i++) mem[wr_ptr + i] = $urandom;
    if (special) begin
      mem[wr_ptr] = 32'h8765_4321;
      mem[wr_ptr + 24] = 32'hFFFF_4321;
    end
    wr_ptr += cnt;
  endtask
  task automatic pulse_start();
    @(posedge CLK);
    #1 start = 1;
    @(posedge CLK);
    #1 start = 0;
  endtask
  task automatic wait_n(input int target);
    for (int i = 0; i < 4000 && n < target; i++) @(posedge CLK);
    check("progress", n >= target, 1);
  endtask
  task automatic wait_done(input int target);
    for (int i = 0; i < 30000 && done_cnt < target; i++) @(posedge CLK);
    check("done_seen", done_cnt, target);
  endtask
  task automatic stall_fetch();
    int p;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      if (fifo_rd_en) break;
    end
    check("fetch_reached", fifo_rd_en, 1);
    stall = 1;
    p = rd_ptr;
    repeat (5) @(posedge CLK);
    #1 check("stall_no_pop", rd_ptr, p);
    stall = 0;
  endtask
  initial begin
    repeat (3) @(posedge CLK);
    #1 rst = 0;
    @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_valid", din_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_done", done, 0);
    check("rst_frame", frame_cnt, 0);
    check("rst_nibble", din_parallel, 0);
    mon_en = 1;
    load(400, 1);
    repeat (3) @(negedge CLK);
    check("idle_no_pop", fifo_rd_en, 0);
    run_base = 0;
    n = 0;
    pulse_start();
    @(negedge CLK);
    check("latency_rd_en", fifo_rd_en, 1);
    @(negedge CLK);
    check("latency_capt", din_valid, 0);
    @(negedge CLK);
    check("latency_valid", din_valid, 1);
    wait_n(8);
    @(negedge CLK);
    check("one_pop_after_word0", rd_ptr, 1);
    full_ready = 0;
    wait_n(20);
    pulse_start();
    @(posedge CLK);
    #1 hold_low = 1;
    repeat (10) @(posedge CLK);
    #1 hold_low = 0;
    stall_fetch();
    stall_fetch();
    wait_done(1);
    @(negedge CLK);
    check("run1_pops", rd_ptr, 400);
    check("frame_hold", frame_cnt, 15);
    check("idle_after_done", busy, 0);
    load(400, 0);
    run_base = 400;
    n = 0;
    pulse_start();
    @(negedge CLK);
    check("restart_frame", frame_cnt, 0);
    check("restart_busy", busy, 1);
    wait_done(2);
    load(40, 0);
    run_base = 800;
    n = 0;
    full_ready = 1;
    pulse_start();
    wait_n(50);
    @(posedge CLK);
    #1 rst = 1;
    mon_en = 0;
    repeat (3) @(posedge CLK);
    #1 rst = 0;
    @(negedge CLK);
    check("midrst_busy", busy, 0);
    check("midrst_valid", din_valid, 0);
    check("midrst_nibble", din_parallel, 0);
    check("midrst_frame", frame_cnt, 0);
    check("midrst_done", done, 0);
    check("midrst_rd_en", fifo_rd_en, 0);
    repeat (5) @(negedge CLK);
    check("midrst_no_pop", fifo_rd_en, 0);
    check("done_total", done_cnt, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
